fetch_decode_unit: RTL

FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

---
 rtl/fetch_decode_unit_pkg.sv | 74 +++++++
 rtl/fetch_decode_unit_instr_decoder.sv | 101 ++++++++++
 rtl/fetch_decode_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fetch_decode_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_decode_unit_pkg
// Shared definitions for the fetch/decode unit: widths, RV32I opcode
// constants, execute-stage control encodings (ALUOp / ALUSrc / ALUSrc1 /
// PCSrc), FSM state encoding and the decoded-instruction bundle.
// No ports (package).
// ---------------------------------------------------------------------------
package fetch_decode_unit_pkg;

  localparam int XLEN       = 32;
  localparam int ALUOPWIDTH = 3;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // ALUOp codes
  localparam logic [ALUOPWIDTH-1:0] ALUOP_R      = 3'd0;
  localparam logic [ALUOPWIDTH-1:0] ALUOP_I      = 3'd1;
  localparam logic [ALUOPWIDTH-1:0] ALUOP_BRANCH = 3'd2;
  localparam logic [ALUOPWIDTH-1:0] ALUOP_J      = 3'd3;
  localparam logic [ALUOPWIDTH-1:0] ALUOP_MEM    = 3'd4;

  // Second ALU operand select
  localparam logic [1:0] ALUSRC_REG  = 2'd0;
  localparam logic [1:0] ALUSRC_IMM  = 2'd1;
  localparam logic [1:0] ALUSRC_FOUR = 2'd2;

  // First ALU operand select
  localparam logic [1:0] ALUSRC1_REG  = 2'd0;
  localparam logic [1:0] ALUSRC1_ZERO = 2'd1;
  localparam logic [1:0] ALUSRC1_PC   = 2'd2;

  // Branch/jump target base
  localparam logic PCSRC_PPC = 1'b0;
  localparam logic PCSRC_REG = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    WAIT_BR = 3'd3,
    TRAP    = 3'd4
  } state_t;

  typedef struct packed {
    logic [ALUOPWIDTH-1:0] alu_op;
    logic [1:0]            alu_src;
    logic [1:0]            alu_src1;
    logic                  pc_src;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [XLEN-1:0]       imm32;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic                  reg_write;
    logic                  is_ctrl;   // branch / JAL / JALR: wait for resolution
    logic                  illegal;
  } decode_t;

  // Sequential PC step; wraps modulo 2^32 naturally.
  function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_decode_unit_instr_decoder.sv
// ---------------------------------------------------------------------------
// instr_decoder
// Purely combinational RV32I decoder producing execute-stage controls.
//   instr : 32-bit instruction word
//   dec   : decoded control bundle (decode_t)
// Register/funct3 fields are passed through raw for every format; an
// unrecognised opcode yields illegal=1 with all controls (incl. reg_write) 0.
// ---------------------------------------------------------------------------
module instr_decoder
  import fetch_decode_unit_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output decode_t         dec
);

  always_comb begin
    dec        = '0;
    dec.funct3 = instr[14:12];
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.rd     = instr[11:7];

    case (instr[6:0])
      OPC_R: begin
        dec.alu_op    = ALUOP_R;
        dec.alu_src   = ALUSRC_REG;
        dec.alu_src1  = ALUSRC1_REG;
        dec.funct7    = instr[31:25];
        dec.reg_write = 1'b1;
      end
      OPC_I: begin
        dec.alu_op    = ALUOP_I;
        dec.alu_src   = ALUSRC_IMM;
        dec.alu_src1  = ALUSRC1_REG;
        dec.imm32     = {{20{instr[31]}}, instr[31:20]};
        // Only shifts carry a meaningful funct7 (SRAI vs SRLI); for other
        // I-ops those bits are immediate and must not leak into funct7.
        if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101)
          dec.funct7 = instr[31:25];
        dec.reg_write = 1'b1;
      end
      OPC_B: begin
        dec.alu_op   = ALUOP_BRANCH;
        dec.alu_src  = ALUSRC_REG;
        dec.alu_src1 = ALUSRC1_REG;
        dec.pc_src   = PCSRC_PPC;
        dec.imm32    = {{19{instr[31]}}, instr[31], instr[7],
                        instr[30:25], instr[11:8], 1'b0};
        dec.is_ctrl  = 1'b1;
      end
      OPC_JAL: begin
        dec.alu_op    = ALUOP_J;
        dec.alu_src   = ALUSRC_FOUR;
        dec.alu_src1  = ALUSRC1_PC;
        dec.pc_src    = PCSRC_PPC;
        dec.imm32     = {{11{instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
        dec.reg_write = 1'b1;
        dec.is_ctrl   = 1'b1;
      end
      OPC_JALR: begin
        dec.alu_op    = ALUOP_J;
        dec.alu_src   = ALUSRC_FOUR;
        dec.alu_src1  = ALUSRC1_PC;
        dec.pc_src    = PCSRC_REG;
        dec.imm32     = {{20{instr[31]}}, instr[31:20]};
        dec.reg_write = 1'b1;
        dec.is_ctrl   = 1'b1;
      end
      OPC_LOAD: begin
        dec.alu_op    = ALUOP_MEM;
        dec.alu_src   = ALUSRC_IMM;
        dec.alu_src1  = ALUSRC1_REG;
        dec.imm32     = {{20{instr[31]}}, instr[31:20]};
        dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        dec.alu_op   = ALUOP_MEM;
        dec.alu_src  = ALUSRC_IMM;
        dec.alu_src1 = ALUSRC1_REG;
        dec.imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_LUI: begin
        dec.alu_op    = ALUOP_MEM;
        dec.alu_src   = ALUSRC_IMM;
        dec.alu_src1  = ALUSRC1_ZERO;
        dec.imm32     = {instr[31:12], 12'b0};
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_op    = ALUOP_MEM;
        dec.alu_src   = ALUSRC_IMM;
        dec.alu_src1  = ALUSRC1_PC;
        dec.imm32     = {instr[31:12], 12'b0};
        dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// ---------------------------------------------------------------------------
// fetch_decode_unit
// Single-issue fetch/decode front end: holds the PC, fetches one instruction
// at a time over a req/ack handshake, presents it decoded to the execute
// stage over a valid/ready handshake and waits for branch resolution on
// control-flow instructions. Illegal opcodes lock the unit in TRAP until rst.
//   clk, rst                         : clock, sync active-high reset
//   imem_req/addr/ack/rdata          : instruction fetch handshake
//   dec_valid/ready/pc/illegal       : decoded-instruction handshake
//   ALUOp..reg_write                 : execute-stage controls
//   br_valid/taken/target            : branch/jump resolution from the ALU
// ---------------------------------------------------------------------------
module fetch_decode_unit
  import fetch_decode_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [31:0]           imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [31:0]           dec_pc,
  output logic                  dec_illegal,
  output logic [ALUOPWIDTH-1:0] ALUOp,
  output logic [1:0]            ALUSrc,
  output logic [1:0]            ALUSrc1,
  output logic                  PCSrc,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic [31:0]           imm32,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic                  reg_write,
  input  logic                  br_valid,
  input  logic                  br_taken,
  input  logic [31:0]           br_target
);

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  decode_t     dec;

  // Targets are forced word-aligned, so the low bits are never consumed.
  logic        unused_br_lsbs;
  assign unused_br_lsbs = ^br_target[1:0];

  instr_decoder u_instr_decoder (
    .instr (instr_q),
    .dec   (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (imem_ack) state_d = DECODE;
      DECODE: begin
        if (dec_ready) begin
          if (dec.illegal)      state_d = TRAP;
          else if (dec.is_ctrl) state_d = WAIT_BR;
          else                  state_d = FETCH;
        end
      end
      WAIT_BR: if (br_valid) state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  // PC and instruction register; ack/br_valid only matter in their own state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      instr_q <= '0;
    end else begin
      if (state_q == FETCH && imem_ack)
        instr_q <= imem_rdata;
      if (state_q == DECODE && dec_ready && !dec.illegal && !dec.is_ctrl)
        pc_q <= pc_step(pc_q);
      if (state_q == WAIT_BR && br_valid)
        pc_q <= br_taken ? {br_target[31:2], 2'b00} : pc_step(pc_q);
    end
  end

  // Outputs are zero outside the state that owns them; decode controls come
  // from the held instruction register so they stay stable across stalls.
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = '0;
    dec_valid   = 1'b0;
    dec_pc      = '0;
    dec_illegal = 1'b0;
    ALUOp       = '0;
    ALUSrc      = '0;
    ALUSrc1     = '0;
    PCSrc       = 1'b0;
    funct3      = '0;
    funct7      = '0;
    imm32       = '0;
    rs1         = '0;
    rs2         = '0;
    rd          = '0;
    reg_write   = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
      end
      DECODE: begin
        dec_valid   = 1'b1;
        dec_pc      = pc_q;
        dec_illegal = dec.illegal;
        ALUOp       = dec.alu_op;
        ALUSrc      = dec.alu_src;
        ALUSrc1     = dec.alu_src1;
        PCSrc       = dec.pc_src;
        funct3      = dec.funct3;
        funct7      = dec.funct7;
        imm32       = dec.imm32;
        rs1         = dec.rs1;
        rs2         = dec.rs2;
        rd          = dec.rd;
        reg_write   = dec.reg_write;
      end
      TRAP:    dec_illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
